mantissa_divider_seq: RTL and testbench

Iterative, parametrised successor to the single-cycle combinational mantissa divider. It divides two normalised significands (hidden 1 implied) by radix-2 restoring division, one quotient bit per cycle. It produces a normalised, rounded result plus an exponent-decrement flag and an inexact flag. It sits in the FP divide datapath between operand unpacking and exponent adjust/pack, and connects to both through valid/ready handshakes.

---
 rtl/mantissa_divider_seq.sv | 148 ++++++++++++++
 tb/tb_mantissa_divider_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_divider_seq.sv
// Sequential radix-2 restoring divider for normalised significands (1.m1 / 1.m2).
// Produces one quotient bit per cycle, then normalises and rounds (RNE or truncate).
module mantissa_divider_seq #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] m2,
    input  logic             rne,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] m3,
    output logic             decrement_exponent,
    output logic             inexact,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH+1:0] r_rem;
    logic [WIDTH:0]   r_div;
    logic [WIDTH+2:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_rne;
    logic [WIDTH-1:0] r_m3;
    logic             r_dec;
    logic             r_inexact;

    logic             w_last;
    logic             w_ge;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_rem_next;
    logic [WIDTH-1:0] w_frac;
    logic             w_guard;
    logic             w_sticky;
    logic             w_dec;
    logic             w_up;
    logic             w_carry;
    logic [WIDTH-1:0] w_sum;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends combinationally on ready, and outputs hold until taken.

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_DIVIDE;
            end
            S_DIVIDE: if (w_last) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_last = (r_cnt == '0);

    // Partial remainder stays below 2D, so the subtraction fits in WIDTH+1 bits.
    assign w_ge       = (r_rem >= {1'b0, r_div});
    assign w_diff     = r_rem[WIDTH:0] - r_div;
    assign w_rem_next = w_ge ? {w_diff, 1'b0} : {r_rem[WIDTH:0], 1'b0};

    always_comb begin
        w_frac   = r_q[WIDTH+1:2];
        w_guard  = r_q[1];
        w_sticky = r_q[0] | (|r_rem);
        w_dec    = 1'b0;
        if (!r_q[WIDTH+2]) begin
            w_frac   = r_q[WIDTH:1];
            w_guard  = r_q[0];
            w_sticky = |r_rem;
            w_dec    = 1'b1;
        end
        w_up             = r_rne & w_guard & (w_sticky | w_frac[0]);
        {w_carry, w_sum} = {1'b0, w_frac} + {{WIDTH{1'b0}}, w_up};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem     <= '0;
            r_div     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_rne     <= 1'b0;
            r_m3      <= '0;
            r_dec     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem <= {1'b0, 1'b1, m1};
                        r_div <= {1'b1, m2};
                        r_rne <= rne;
                        r_q   <= '0;
                        r_cnt <= CW'(WIDTH + 2);
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[WIDTH+1:0], w_ge};
                    if (!w_last) r_cnt <= r_cnt - CW'(1);
                end
                S_ROUND: begin
                    // A rounding carry-out wraps the fraction to zero; a sub-1 quotient
                    // then becomes exactly 1.0, so the exponent decrement is dropped.
                    r_m3      <= w_sum;
                    r_dec     <= w_dec & ~w_carry;
                    r_inexact <= w_guard | w_sticky;
                end
                default: ;
            endcase
        end
    end

    assign m3                 = r_m3;
    assign decrement_exponent = r_dec;
    assign inexact            = r_inexact;
    assign dbg_state          = r_state;

endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Bench for mantissa_divider_seq: WIDTH=23 and WIDTH=8 instances run side by side
// against an exact-arithmetic quotient model.
module tb_mantissa_divider_seq;
  localparam int WA = 23;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          rne = 1'b0;
  logic          out_ready = 1'b0;
  logic [WA-1:0] a_m1 = '0, a_m2 = '0, a_m3;
  logic [WB-1:0] b_m1 = '0, b_m2 = '0, b_m3;
  logic          a_in_ready, a_out_valid, a_dec, a_inx;
  logic          b_in_ready, b_out_valid, b_dec, b_inx;
  logic [1:0]    a_dbg, b_dbg;

  logic [WA+1:0] exp_q_a[$];
  logic [WB+1:0] exp_q_b[$];
  logic [WA+1:0] last_a;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_bad_carry = 0;

  mantissa_divider_seq #(.WIDTH(WA)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .m1(a_m1), .m2(a_m2), .rne(rne), .out_valid(a_out_valid), .out_ready(out_ready),
    .m3(a_m3), .decrement_exponent(a_dec), .inexact(a_inx), .dbg_state(a_dbg)
  );

  mantissa_divider_seq #(.WIDTH(WB)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .m1(b_m1), .m2(b_m2), .rne(rne), .out_valid(b_out_valid), .out_ready(out_ready),
    .m3(b_m3), .decrement_exponent(b_dec), .inexact(b_inx), .dbg_state(b_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact model: quotient scaled so the leading 1 sits at weight 2^w; the remainder
  // of that integer division decides rounding and inexact.
  function automatic logic [63:0] ref_div(input int w, input longint unsigned x,
                                          input longint unsigned y, input bit r);
    longint unsigned one, n, d, sc, rem, frac;
    bit dec, inx, up;
    one = 64'd1 << w;
    n = one + x;
    d = one + y;
    if (n >= d) begin
      dec = 1'b0;
      sc  = (n << w) / d;
      rem = (n << w) % d;
    end else begin
      dec = 1'b1;
      sc  = (n << (w + 1)) / d;
      rem = (n << (w + 1)) % d;
    end
    frac = sc - one;
    inx  = (rem != 0);
    up   = r && ((2 * rem > d) || ((2 * rem == d) && frac[0]));
    frac = frac + longint'(up);
    if (frac == one) begin
      frac = 0;
      if (dec) dec = 1'b0;
      else n_bad_carry++;
    end
    return (longint'(dec) << (w + 1)) | (longint'(inx) << w) | frac;
  endfunction

  // driver: issue to both instances, wait for both results, hold, then hand shake
  task automatic do_op(input logic [WA-1:0] x, input logic [WA-1:0] y, input logic r,
                       input int hold);
    logic [63:0]   ea, eb;
    logic [WA+1:0] got_a, want_a;
    logic [WB+1:0] got_b, want_b;
    int lat, lat_a, lat_b;
    ea = ref_div(WA, longint'(x), longint'(y), r);
    eb = ref_div(WB, longint'(x[WB-1:0]), longint'(y[WB-1:0]), r);
    exp_q_a.push_back(ea[WA+1:0]);
    exp_q_b.push_back(eb[WB+1:0]);
    a_m1 = x; a_m2 = y; b_m1 = x[WB-1:0]; b_m2 = y[WB-1:0];
    rne = r; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_m1 = WA'($urandom); a_m2 = WA'($urandom); b_m1 = WB'($urandom); b_m2 = WB'($urandom);
    rne = ~r;
    check("busy_a", a_in_ready, 0);
    check("busy_b", b_in_ready, 0);
    lat = 0; lat_a = -1; lat_b = -1;
    while ((lat_a < 0 || lat_b < 0) && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat_a < 0 && a_out_valid) lat_a = lat;
      if (lat_b < 0 && b_out_valid) lat_b = lat;
    end
    check("latency_a", lat_a, WA + 4);
    check("latency_b", lat_b, WB + 4);
    got_a = {a_dec, a_inx, a_m3};
    got_b = {b_dec, b_inx, b_m3};
    want_a = exp_q_a.pop_front();
    want_b = exp_q_b.pop_front();
    check("result_a", got_a, want_a);
    check("result_b", got_b, want_b);
    last_a = got_a;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a_m1 = WA'($urandom);
      @(negedge clk);
      check("hold_result_a", {a_dec, a_inx, a_m3}, want_a);
      check("hold_valid_a", a_out_valid, 1);
      check("hold_ready_a", a_in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_a", a_in_ready, 1);
    check("idle_ready_b", b_in_ready, 1);
    check("idle_valid_a", a_out_valid, 0);
  endtask

  initial begin
    logic [WA-1:0] x, y;
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    check("rst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
    check("rst_result_a", {a_dec, a_inx, a_m3}, 0);
    check("rst_result_b", {b_dec, b_inx, b_m3}, 0);

    do_op(23'h000000, 23'h000000, 1'b1, 0);
    check("dir_1.0/1.0", last_a, {1'b0, 1'b0, 23'h000000});
    do_op(23'h400000, 23'h000000, 1'b1, 0);
    check("dir_1.5/1.0", last_a, {1'b0, 1'b0, 23'h400000});
    do_op(23'h000000, 23'h400000, 1'b1, 0);
    check("dir_1.0/1.5_rne", last_a, {1'b1, 1'b1, 23'h2AAAAB});
    do_op(23'h000000, 23'h400000, 1'b0, 10);
    check("dir_1.0/1.5_trunc", last_a, {1'b1, 1'b1, 23'h2AAAAA});

    // reset at DIVIDE iteration 10 discards the operation
    a_m1 = 23'h123456; a_m2 = 23'h654321; b_m1 = 8'h5A; b_m2 = 8'hA5; rne = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    check("midrst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
    check("midrst_result_a", {a_dec, a_inx, a_m3}, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_out_valid || b_out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    do_op(23'h400000, 23'h000000, 1'b0, 0);
    check("post_rst_1.5/1.0", last_a, {1'b0, 1'b0, 23'h400000});

    for (int k = 0; k < 1200; k++) begin
      x = WA'($urandom);
      y = WA'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: y = '1;
        2: y = x;
        default: begin x = '1; y = WA'($urandom_range(0, 3)); end
      endcase
      do_op(x, y, 1'($urandom), ($urandom_range(0, 15) == 0) ? 2 : 0);
    end

    check("no_carry_with_dec0", n_bad_carry, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
